// File: rtl/muldiv_stall.sv
// muldiv_stall: iterative HI/LO multiply/divide unit for the EX stage.
//   Runs MULT, MULTU, DIV and DIVU over N+1 cycles: N shift-add or restoring
//   iterations followed by one sign-fix/writeback cycle. MTHI/MTLO writes are
//   taken only while idle. stall freezes IF/ID and ID/EX whenever a HI/LO
//   access or a new op arrives while an op is still in flight.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   issue op (re-held by the pipeline while stalled)
//   op       in   [1:0] 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b     in   [N-1:0] rs / rt operands
//   rd_hi    in   MFHI in EX
//   rd_lo    in   MFLO in EX
//   wr_hi    in   MTHI in EX
//   wr_lo    in   MTLO in EX
//   wdata    in   [N-1:0] MTHI/MTLO data
//   hi, lo   out  [N-1:0] HI/LO registers
//   busy     out  op in flight (registered)
//   done     out  one-cycle pulse once hi/lo hold the new result
//   stall    out  hold request to the pipeline registers
//
// state  | meaning
// IDLE   | waiting; accepts start or MTHI/MTLO writes
// RUN    | one multiply/divide iteration per clock, count 0..N-1
// FIX    | sign correction and hi/lo writeback, done pulse
module muldiv_stall #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         rd_hi,
    input  logic         rd_lo,
    input  logic         wr_hi,
    input  logic         wr_lo,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         stall
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          is_div;
    logic          neg_q;     // product / quotient must be negated
    logic          neg_r;     // remainder takes the dividend's sign
    logic          b_zero;
    logic [N-1:0]  mag_d;     // |multiplicand| or |divisor|
    logic [N-1:0]  acc_hi;    // product high half / partial remainder
    logic [N-1:0]  acc_lo;    // multiplier bits / dividend-then-quotient bits

    logic          a_neg;
    logic          b_neg;
    logic [N-1:0]  mag_a;
    logic [N-1:0]  mag_b;
    logic [N:0]    mul_sum;
    logic [N:0]    div_shift;
    logic          div_fits;
    logic [N-1:0]  div_diff;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_neg;
    logic [N-1:0]  quo_neg;
    logic [N-1:0]  rem_neg;

    assign a_neg = op[0] & a[N-1];
    assign b_neg = op[0] & b[N-1];
    assign mag_a = a_neg ? (~a + ONE_N) : a;
    assign mag_b = b_neg ? (~b + ONE_N) : b;

    // Shift-add: the carry out of the upper-half add shifts down into bit N-1.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_d} : '0);

    // Restoring divide: the shifted remainder needs N+1 bits before the compare.
    assign div_shift = {acc_hi, acc_lo[N-1]};
    assign div_fits  = (div_shift >= {1'b0, mag_d});
    assign div_diff  = div_shift[N-1:0] - mag_d;

    assign prod     = {acc_hi, acc_lo};
    assign prod_neg = ~prod + ONE_2N;
    assign quo_neg  = ~acc_lo + ONE_N;
    assign rem_neg  = ~acc_hi + ONE_N;

    assign stall = busy & (start | rd_hi | rd_lo | wr_hi | wr_lo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            mag_d  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        b_zero <= (b == '0);
                        mag_d  <= op[1] ? mag_b : mag_a;
                        acc_hi <= '0;
                        acc_lo <= op[1] ? mag_a : mag_b;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        acc_hi <= div_fits ? div_diff : div_shift[N-1:0];
                        acc_lo <= {acc_lo[N-2:0], div_fits};
                    end else begin
                        acc_hi <= mul_sum[N:1];
                        acc_lo <= {mul_sum[0], acc_lo[N-1:1]};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(N - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (is_div) begin
                        // A zero divisor yields an all-ones quotient regardless of sign;
                        // the remainder path already reproduces the dividend.
                        lo <= b_zero ? '1 : (neg_q ? quo_neg : acc_lo);
                        hi <= neg_r ? rem_neg : acc_hi;
                    end else begin
                        {hi, lo} <= neg_q ? prod_neg : prod;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_stall.sv
module tb_muldiv_stall;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hi;
    logic        rd_lo;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_stall #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .rd_hi (rd_hi),
        .rd_lo (rd_lo),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .stall (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] res;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'b00: res = {32'b0, x} * {32'b0, y};
            2'b01: res = sx * sy;
            2'b10: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Issues one op from idle and waits (bounded) for busy to drop.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int bcyc, output int dcnt, output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcyc = 0;
        dcnt = 0;
        while (busy === 1'b1 && bcyc < 100) begin
            bcyc++;
            dcnt += int'(done);
            @(negedge clk);
        end
        h = hi;
        l = lo;
        dcnt += int'(done);
        @(negedge clk);
        dcnt += int'(done);
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL reset_hilo got %h exp 0", {hi, lo}); end
        n_cmp++; if ({busy, done, stall} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {busy, done, stall}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'hAAAA_5555;
        @(negedge clk);
        wr_hi = 1'b0;
        op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_lo = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL reset_pre_stall got %b exp 1", stall); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL reset_async_hilo got %h exp 0", {hi, lo}); end
        n_cmp++; if ({busy, stall} !== 2'b00) begin n_bad++; $display("FAIL reset_async_busy_stall got %b exp 00", {busy, stall}); end
        rd_lo = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int dseen;
            dseen = 0;
            repeat (40) begin @(negedge clk); dseen += int'(done); end
            n_cmp++; if ({hi, lo, busy} !== 65'h0 || dseen != 0) begin n_bad++; $display("FAIL reset_abort got hilo %h busy %b done %0d exp 0", {hi, lo}, busy, dseen); end
        end
    endtask

    task automatic test_vectors;
        logic [1:0]  vo [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11};
        logic [31:0] va [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FFFB};
        logic [31:0] vb [6] = '{32'hFFFF_FFFF, 32'd6, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] vh [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'h0, 32'hFFFF_FFFB};
        logic [31:0] vl [6] = '{32'h0000_0001, 32'hFFFF_FFD6, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        int bc, dc;
        logic [31:0] h, l;
        for (int i = 0; i < 6; i++) begin
            do_op(vo[i], va[i], vb[i], bc, dc, h, l);
            n_cmp++; if (h !== vh[i]) begin n_bad++; $display("FAIL vec%0d_hi got %h exp %h", i, h, vh[i]); end
            n_cmp++; if (l !== vl[i]) begin n_bad++; $display("FAIL vec%0d_lo got %h exp %h", i, l, vl[i]); end
            n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL vec%0d_busy_cycles got %0d exp 33", i, bc); end
            n_cmp++; if (dc != 1) begin n_bad++; $display("FAIL vec%0d_done_pulses got %0d exp 1", i, dc); end
        end
    endtask

    task automatic test_random;
        int bc, dc;
        logic [31:0] h, l, x, y;
        logic [1:0] o;
        logic [63:0] exp_r;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1, 2:    y = 32'($urandom_range(1, 15));
                3:       y = -32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) x = 32'h8000_0000;
            exp_r = model(o, x, y);
            do_op(o, x, y, bc, dc, h, l);
            n_cmp++; if ({h, l} !== exp_r || bc != 33) begin
                n_bad++;
                $display("FAIL rand%0d op%0d a=%h b=%h got %h/%0d exp %h/33", i, o, x, y, {h, l}, bc, exp_r);
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] x, y;
        logic [63:0] exp_r;
        int cnt;
        x = $urandom;
        y = $urandom;
        exp_r = model(2'b00, x, y);
        @(negedge clk);
        op = 2'b00; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stall_no_request got %b exp 0", stall); end
        @(negedge clk);
        rd_lo = 1'b1;
        #1;
        cnt = 0;
        while (stall === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        n_cmp++; if (cnt != 32) begin n_bad++; $display("FAIL stall_mflo_cycles got %0d exp 32", cnt); end
        n_cmp++; if (lo !== exp_r[31:0] || busy !== 1'b0) begin n_bad++; $display("FAIL stall_release_lo got %h busy %b exp %h busy 0", lo, busy, exp_r[31:0]); end
        rd_lo = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] x1, y1, x2, y2;
        logic [63:0] e1, e2;
        int cnt, st;
        x1 = $urandom; y1 = $urandom;
        x2 = $urandom; y2 = 32'($urandom_range(1, 1000));
        e1 = model(2'b01, x1, y1);
        e2 = model(2'b10, x2, y2);
        @(negedge clk);
        op = 2'b01; a = x1; b = y1; start = 1'b1;
        @(negedge clk);
        op = 2'b10; a = x2; b = y2;
        #1;
        cnt = 0;
        st = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            st += int'(stall);
            @(negedge clk);
            #1;
        end
        n_cmp++; if (cnt != 33 || st != 33) begin n_bad++; $display("FAIL b2b_first_busy got busy %0d stall %0d exp 33 33", cnt, st); end
        n_cmp++; if ({hi, lo} !== e1 || done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_result got %h done %b exp %h done 1", {hi, lo}, done, e1); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_release_stall got %b exp 0", stall); end
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got busy %b exp 1", busy); end
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++; if ({hi, lo} !== e2 || cnt != 33) begin n_bad++; $display("FAIL b2b_second got %h/%0d exp %h/33", {hi, lo}, cnt, e2); end
    endtask

    task automatic test_mthi_mtlo;
        int cnt;
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        wr_hi = 1'b0;
        n_cmp++; if (hi !== 32'h0000_1234) begin n_bad++; $display("FAIL mthi got %h exp 00001234", hi); end
        wr_lo = 1'b1; wdata = 32'h0000_5678;
        @(negedge clk);
        wr_lo = 1'b0;
        n_cmp++; if (lo !== 32'h0000_5678) begin n_bad++; $display("FAIL mtlo got %h exp 00005678", lo); end
        op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        n_cmp++; if (lo !== 32'h0000_5678 || busy !== 1'b1) begin n_bad++; $display("FAIL start_beats_mtlo got lo %h busy %b exp 00005678 1", lo, busy); end
        wr_hi = 1'b1; wdata = 32'h0000_BEEF;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++; if ({hi, lo} !== 64'd15) begin n_bad++; $display("FAIL mthi_ignored_busy got %h exp 15", {hi, lo}); end
        @(negedge clk);
        wr_hi = 1'b0;
        n_cmp++; if (hi !== 32'h0000_BEEF) begin n_bad++; $display("FAIL mthi_after_release got %h exp 0000beef", hi); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; op = 2'b00; a = '0; b = '0;
        rd_hi = 1'b0; rd_lo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        test_reset;
        test_vectors;
        test_random;
        test_stall;
        test_back_to_back;
        test_mthi_mtlo;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
